// File: rtl/bf2_sdf_stage.sv
// bf2_sdf_stage: radix-2^2 single-path delay feedback stage.
// BF2I (feedback depth 2*FB_DEPTH) -> registered -j rotator -> BF2II
// (feedback depth FB_DEPTH). Every half advances only on its own input valid.
// Optional feature macro BF2_ROUND_SCALE_EN: butterfly results are rounded
// half-up and halved; without it they wrap to DATA_WIDTH bits unscaled.
module bf2_sdf_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int FB_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic signed [DATA_WIDTH-1:0] in_re,
  input  logic signed [DATA_WIDTH-1:0] in_im,
  output logic                         out_valid,
  output logic                         out_sof,
  output logic signed [DATA_WIDTH-1:0] out_re,
  output logic signed [DATA_WIDTH-1:0] out_im
);

  localparam int L1  = 2 * FB_DEPTH;
  localparam int L2  = FB_DEPTH;
  localparam int CW  = $clog2(4 * FB_DEPTH);
  localparam int B1  = $clog2(L1);
  localparam int B2  = $clog2(L2);
  localparam int FW1 = B1 + 1;
  localparam int FW2 = B2 + 1;

  localparam logic [FW1-1:0] FULL1 = FW1'(L1);
  localparam logic [FW2-1:0] FULL2 = FW2'(L2);
  localparam logic [CW-1:0]  M_ROT = CW'(3 * FB_DEPTH);
  // BF2II output group index 0 is produced when its input index is D.
  localparam logic [CW-1:0]  M_SOF = CW'(FB_DEPTH);

  typedef logic signed [DATA_WIDTH-1:0] smp_t;
  typedef logic signed [DATA_WIDTH:0]   wide_t;

  function automatic wide_t ext(input smp_t a);
    return {a[DATA_WIDTH-1], a};
  endfunction

  // Reduce a DATA_WIDTH+1 butterfly result back to DATA_WIDTH.
  function automatic smp_t reduce(input wide_t s);
`ifdef BF2_ROUND_SCALE_EN
    // One extra guard bit so that adding the rounding constant cannot overflow.
    logic signed [DATA_WIDTH+1:0] t;
    t = $signed({s[DATA_WIDTH], s}) + $signed({{(DATA_WIDTH+1){1'b0}}, 1'b1});
    t = t >>> 1;
    return smp_t'(t);
`else
    return smp_t'(s);
`endif
  endfunction

  // Negation for the -j rotation wraps (only the most negative value is affected).
  function automatic smp_t neg(input smp_t a);
    return -a;
  endfunction

  // ---------------- BF2I ----------------
  logic [CW-1:0]  cnt1, cnt1_eff;
  logic [FW1-1:0] fill1;
  smp_t           dl1_re [L1];
  smp_t           dl1_im [L1];
  logic           acc1, c1;
  smp_t           o1_re, o1_im, st1_re, st1_im;
  logic           vld_p0;
  smp_t           re_p0, im_p0;

  // BF2I butterfly: pass-through/delay on the first half, sum/difference on the second.
  always_comb begin
    acc1     = in_valid & ~flush;
    cnt1_eff = in_sof ? '0 : cnt1;
    c1       = cnt1_eff[B1];
    o1_re    = dl1_re[L1-1];
    o1_im    = dl1_im[L1-1];
    st1_re   = in_re;
    st1_im   = in_im;
    if (c1) begin
      o1_re  = reduce(ext(dl1_re[L1-1]) + ext(in_re));
      o1_im  = reduce(ext(dl1_im[L1-1]) + ext(in_im));
      st1_re = reduce(ext(dl1_re[L1-1]) - ext(in_re));
      st1_im = reduce(ext(dl1_im[L1-1]) - ext(in_im));
    end
  end

  // Stage p0: BF2I counter, feedback line and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt1   <= '0;
      fill1  <= '0;
      vld_p0 <= 1'b0;
      re_p0  <= '0;
      im_p0  <= '0;
      for (int i = 0; i < L1; i++) begin
        dl1_re[i] <= '0;
        dl1_im[i] <= '0;
      end
    end else if (flush) begin
      cnt1   <= '0;
      fill1  <= '0;
      vld_p0 <= 1'b0;
      re_p0  <= '0;
      im_p0  <= '0;
      for (int i = 0; i < L1; i++) begin
        dl1_re[i] <= '0;
        dl1_im[i] <= '0;
      end
    end else begin
      vld_p0 <= acc1 && (fill1 == FULL1);
      if (acc1) begin
        cnt1 <= cnt1_eff + 1'b1;
        if (fill1 != FULL1) fill1 <= fill1 + 1'b1;
        dl1_re[0] <= st1_re;
        dl1_im[0] <= st1_im;
        for (int i = 1; i < L1; i++) begin
          dl1_re[i] <= dl1_re[i-1];
          dl1_im[i] <= dl1_im[i-1];
        end
        if (fill1 == FULL1) begin
          re_p0 <= o1_re;
          im_p0 <= o1_im;
        end
      end
    end
  end

  // ---------------- -j rotator ----------------
  logic [CW-1:0] cnt2, m_p1;
  logic          vld_p1;
  smp_t          re_p1, im_p1;

  // Stage p1: count BF2I outputs and rotate the last quarter of each group by -j.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt2   <= '0;
      m_p1   <= '0;
      vld_p1 <= 1'b0;
      re_p1  <= '0;
      im_p1  <= '0;
    end else if (flush) begin
      cnt2   <= '0;
      m_p1   <= '0;
      vld_p1 <= 1'b0;
      re_p1  <= '0;
      im_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        cnt2 <= cnt2 + 1'b1;
        m_p1 <= cnt2;
        if (cnt2 >= M_ROT) begin
          re_p1 <= im_p0;
          im_p1 <= neg(re_p0);
        end else begin
          re_p1 <= re_p0;
          im_p1 <= im_p0;
        end
      end
    end
  end

  // ---------------- BF2II ----------------
  logic [FW2-1:0] fill2;
  smp_t           dl2_re [L2];
  smp_t           dl2_im [L2];
  logic           c2;
  smp_t           o2_re, o2_im, st2_re, st2_im;
  logic           vld_p2, sof_p2;
  smp_t           re_p2, im_p2;

  // BF2II butterfly, controlled by the group index carried with the rotated sample.
  always_comb begin
    c2     = m_p1[B2];
    o2_re  = dl2_re[L2-1];
    o2_im  = dl2_im[L2-1];
    st2_re = re_p1;
    st2_im = im_p1;
    if (c2) begin
      o2_re  = reduce(ext(dl2_re[L2-1]) + ext(re_p1));
      o2_im  = reduce(ext(dl2_im[L2-1]) + ext(im_p1));
      st2_re = reduce(ext(dl2_re[L2-1]) - ext(re_p1));
      st2_im = reduce(ext(dl2_im[L2-1]) - ext(im_p1));
    end
  end

  // Stage p2: BF2II feedback line and the registered stage outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill2  <= '0;
      vld_p2 <= 1'b0;
      sof_p2 <= 1'b0;
      re_p2  <= '0;
      im_p2  <= '0;
      for (int i = 0; i < L2; i++) begin
        dl2_re[i] <= '0;
        dl2_im[i] <= '0;
      end
    end else if (flush) begin
      fill2  <= '0;
      vld_p2 <= 1'b0;
      sof_p2 <= 1'b0;
      re_p2  <= '0;
      im_p2  <= '0;
      for (int i = 0; i < L2; i++) begin
        dl2_re[i] <= '0;
        dl2_im[i] <= '0;
      end
    end else begin
      vld_p2 <= vld_p1 && (fill2 == FULL2);
      sof_p2 <= vld_p1 && (fill2 == FULL2) && (m_p1 == M_SOF);
      if (vld_p1) begin
        if (fill2 != FULL2) fill2 <= fill2 + 1'b1;
        dl2_re[0] <= st2_re;
        dl2_im[0] <= st2_im;
        for (int i = 1; i < L2; i++) begin
          dl2_re[i] <= dl2_re[i-1];
          dl2_im[i] <= dl2_im[i-1];
        end
        if (fill2 == FULL2) begin
          re_p2 <= o2_re;
          im_p2 <= o2_im;
        end
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_sof   = sof_p2;
  assign out_re    = re_p2;
  assign out_im    = im_p2;

endmodule
